// File: rtl/sclk_monitor_if.sv
// sclk_monitor_if: slow clock under test plus the monitor's edge, measurement and status outputs
interface sclk_monitor_if #(parameter int CNT_W = 27);
  logic             sclk;
  logic             edge_p;
  logic             edge_n;
  logic [CNT_W-1:0] half_len;
  logic             len_vld;
  logic             locked;
  logic             fault;
  modport master (output sclk, input edge_p, edge_n, half_len, len_vld, locked, fault);
  modport slave (input sclk, output edge_p, edge_n, half_len, len_vld, locked, fault);
endinterface

// File: rtl/sclk_monitor.sv
// sclk_monitor: synchronises SCLK into CLK, measures each half period and tracks lock/fault
// Define SCLK_MON_FILTER_EN to insert a FILT_LEN-sample stability filter ahead of edge detection.
module sclk_monitor #(
  parameter int HALF_PERIOD = 50000001,
  parameter int TOL         = 1000,
  parameter int LOCK_CNT    = 4,
  parameter int CNT_W       = 27
`ifdef SCLK_MON_FILTER_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input logic           CLK,
  input logic           rst_n,
  sclk_monitor_if.slave mon
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0] HI = (CNT_W + 1)'(HALF_PERIOD + TOL);
  localparam logic [CNT_W:0] LO = (CNT_W + 1)'(HALF_PERIOD > TOL ? HALF_PERIOD - TOL : 0);
  typedef enum logic [1:0] {IDLE, MEAS, LOCKED, FAULT} state_t;
  state_t           state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic             s1_q, s2_q, prev_q, lvl, sclk_edge;
  logic             stall_q, stall, in_rng, ev_ok, ev_bad;
  logic [CNT_W-1:0] cnt_q, half_len_q;
  logic [CNT_W:0]   meas;
  logic             edge_p_q, edge_n_q, len_vld_q;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) {s1_q, s2_q} <= '0;
    else {s1_q, s2_q} <= {mon.sclk, s1_q};
`ifdef SCLK_MON_FILTER_EN
  logic [FILT_LEN-2:0] hist_q;
  logic [FILT_LEN-1:0] win;
  logic                filt_q;
  assign win = {hist_q, s2_q};
  // level flips only once the whole window (including s2) agrees
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= win[FILT_LEN-2:0];
      filt_q <= (&win) | (filt_q & (|win));
    end
  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif
  assign sclk_edge = lvl ^ prev_q;
  assign meas      = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign in_rng    = meas >= LO && meas <= HI;
  assign stall     = !sclk_edge && !stall_q && meas > HI;
  assign ev_ok     = sclk_edge && in_rng;
  assign ev_bad    = (sclk_edge && !in_rng) || stall;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      half_len_q <= '0;
      len_vld_q  <= 1'b0;
      edge_p_q   <= 1'b0;
      edge_n_q   <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      prev_q    <= lvl;
      cnt_q     <= sclk_edge ? '0 : cnt_q + CNT_W'(!(&cnt_q));
      edge_p_q  <= sclk_edge & lvl;
      edge_n_q  <= sclk_edge & ~lvl;
      len_vld_q <= sclk_edge && state_q != IDLE;
      if (sclk_edge && state_q != IDLE) half_len_q <= meas[CNT_W-1:0];
      stall_q   <= !sclk_edge && (stall_q || stall);
    end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  // first edge after reset is only a reference point
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      IDLE: state_d = sclk_edge ? MEAS : IDLE;
      MEAS:
        if (ev_ok) begin
          good_d  = good_q == GW'(LOCK_CNT - 1) ? '0 : good_q + GW'(1);
          state_d = good_q == GW'(LOCK_CNT - 1) ? LOCKED : MEAS;
        end else if (ev_bad) good_d = '0;
      LOCKED: state_d = ev_bad ? FAULT : LOCKED;
      FAULT:
        if (ev_ok) begin
          state_d = MEAS;
          good_d  = GW'(1);
        end
      default: state_d = IDLE;
    endcase
  end
  assign mon.edge_p   = edge_p_q;
  assign mon.edge_n   = edge_n_q;
  assign mon.half_len = half_len_q;
  assign mon.len_vld  = len_vld_q;
  assign mon.locked   = state_q == LOCKED;
  assign mon.fault    = state_q == FAULT;
endmodule

// File: tb/tb_sclk_monitor.sv
// tb_sclk_monitor: random and directed SCLK stimulus against a cycle model built from sampled-level history
module tb_sclk_monitor;
  localparam int HP = 10, TOL = 1, LK = 4, CW = 8, MAXN = 20000;
`ifdef SCLK_MON_FILTER_EN
  localparam int W = 4, D = 3;
`else
  localparam int W = 1, D = 2;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  sclk_monitor_if #(.CNT_W(CW)) mon ();
  sclk_monitor #(.HALF_PERIOD(HP), .TOL(TOL), .LOCK_CNT(LK), .CNT_W(CW)) dut (
    .CLK(clk), .rst_n(rst_n), .mon(mon));
  always #5 clk = ~clk;
  bit xa [0:MAXN];
  bit ya [0:MAXN];
  int n, last, mode, good;
  bit have_ref, m_ep, m_en, m_vld;
  logic [CW-1:0] m_hl;
  int errs = 0, checks = 0, exp_lit = 0, pin = 0;
  bit lit_on = 0;
  function automatic bit yv(int j);
    return (j < 1) ? 1'b0 : ya[j];
  endfunction
  // mode 0: measuring, 1: locked, 2: fault
  function automatic void judge(bit ok);
    if (mode == 0) begin
      good = ok ? good + 1 : 0;
      if (good == LK) begin
        mode = 1;
        good = 0;
      end
    end else if (mode == 1) begin
      if (!ok) mode = 2;
    end else if (ok) begin
      mode = 0;
      good = 1;
    end
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; have_ref = 0; mode = 0; good = 0; last = 0;
      m_ep = 0; m_en = 0; m_vld = 0; m_hl = '0;
    end else begin
      bit st;
      int meas;
      n++;
      xa[n] = mon.sclk;
      st = 1;
      for (int i = 0; i < W; i++) if (((n - i >= 1) ? xa[n-i] : 1'b0) != mon.sclk) st = 0;
      ya[n] = st ? mon.sclk : yv(n - 1);
      m_ep = 0; m_en = 0; m_vld = 0;
      if (yv(n - D) != yv(n - D - 1)) begin
        m_ep = yv(n - D);
        m_en = !yv(n - D);
        if (have_ref) begin
          meas = (n - last > 256) ? 256 : n - last;
          m_hl = meas[CW-1:0];
          m_vld = 1;
          judge(meas >= HP - TOL && meas <= HP + TOL);
        end
        have_ref = 1;
        last = n;
      end else if (have_ref && n - last == HP + TOL + 1) judge(0);
    end
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) chk("reset_outputs",
      int'({mon.edge_p, mon.edge_n, mon.len_vld, mon.locked, mon.fault, mon.half_len}), 0);
    else begin
      chk("edge_p", mon.edge_p, m_ep);
      chk("edge_n", mon.edge_n, m_en);
      chk("len_vld", mon.len_vld, m_vld);
      chk("half_len", mon.half_len, m_hl);
      chk("locked", mon.locked, mode == 1 && have_ref);
      chk("fault", mon.fault, mode == 2);
      if (lit_on && mon.len_vld) chk("lit_half_len", mon.half_len, exp_lit);
      if (pin != 0) begin
        chk("pin_locked", mon.locked, pin == 1);
        chk("pin_fault", mon.fault, pin == 2);
      end
    end
  end
  task automatic tog_after(int len, int p);
    repeat (len - 1) @(negedge clk);
    pin = p;
    @(negedge clk);
    #2;
    pin = 0;
    exp_lit = len;
    mon.sclk = ~mon.sclk;
  endtask
  task automatic async_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  initial begin
    int len;
    mon.sclk = 1'b0;
    repeat (4) tog_after(2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tog_after(4, 0);
    lit_on = 1;
    for (int i = 0; i < 8; i++) tog_after(10, i == 3 ? 3 : i == 4 ? 1 : 0);
    lit_on = 0;
    async_pulse();
    tog_after(6, 0);
    tog_after(10, 0);
    lit_on = 1;
    for (int i = 0; i < 6; i++) tog_after(10, i == 5 ? 1 : 0);
    lit_on = 0;
    @(negedge clk);
    rst_n = 1'b0;
    mon.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tog_after(4, 0);
    lit_on = 1;
    tog_after(9, 0); tog_after(11, 0); tog_after(9, 0); tog_after(11, 3); tog_after(9, 1);
    tog_after(13, 1); tog_after(10, 2); tog_after(10, 3); tog_after(10, 3); tog_after(10, 3);
    tog_after(10, 1);
    repeat (20) @(negedge clk);
    lit_on = 0;
    pin = 2;
    repeat (270) @(negedge clk);
    pin = 0;
    #2 mon.sclk = ~mon.sclk;
    tog_after(10, 2);
    tog_after(10, 0);
    repeat (4) @(negedge clk);
    #2 mon.sclk = ~mon.sclk;
    repeat (2) @(negedge clk);
    #2 mon.sclk = ~mon.sclk;
    repeat (12) @(negedge clk);
    repeat (300) begin
      if ($urandom_range(0, 60) == 0) async_pulse();
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : int'($urandom_range(8, 12));
      repeat (len) @(negedge clk);
      #2 mon.sclk = ~mon.sclk;
    end
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
